// File: rtl/timer_pkg.sv
// Shared types and helpers for the cooking-timer keypad front end.
// Provides the controller state encoding and the one-hot key to BCD decode.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;

  typedef struct packed {
    logic             valid;
    logic [BCD_W-1:0] bcd;
  } bcd_key_t;

  // valid only when exactly one key bit is set; chords decode as invalid
  function automatic bcd_key_t onehot_to_bcd(input logic [9:0] key);
    bcd_key_t    res;
    int unsigned cnt;
    res = '0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (key[i]) begin
        cnt++;
        res.bcd = BCD_W'(i);
      end
    end
    res.valid = (cnt == 1);
    return res;
  endfunction

endpackage

// File: rtl/time_entry_edge_det.sv
// Registered edge detector for debounced button/key inputs.
// FROM_QUIET restricts edges to those leaving an all-inactive previous sample.
module edge_det #(
  parameter int WIDTH      = 1,
  parameter bit FALLING    = 1'b0,
  parameter bit FROM_QUIET = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sig,
  output logic [WIDTH-1:0] o_edge
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_raw;
  logic             w_quiet;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= '0;
    else          r_q <= i_sig;
  end

  assign w_raw   = FALLING ? (~i_sig & r_q) : (i_sig & ~r_q);
  assign w_quiet = FALLING ? (r_q == '1) : (r_q == '0);
  assign o_edge  = (FROM_QUIET && !w_quiet) ? '0 : w_raw;

endmodule

// File: rtl/time_entry.sv
// Keypad entry controller: collects BCD digits, strobes loadn into the counter chain.
// Optional seconds clamp on load is enabled by defining TIME_ENTRY_CLAMP_EN.
module time_entry
  import timer_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SEC_LIMIT = 5
) (
  input  logic                         clk,
  input  logic                         clrn,
  input  logic [9:0]                   key,
  input  logic                         startn,
  input  logic                         cleann,
  input  logic                         timer_zero,
  output logic [4*DIGITS-1:0]          data,
  output logic                         loadn,
  output logic [$clog2(DIGITS+1)-1:0]  ndigits,
  output logic                         busy
);

  localparam int DW = BCD_W * DIGITS;
  localparam int NW = $clog2(DIGITS + 1);
`ifdef TIME_ENTRY_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t          r_state, w_state_nxt;
  logic [DW-1:0]   r_data, w_data_nxt, w_data_shift, w_data_clamped;
  logic [NW-1:0]   r_ndigits, w_ndigits_nxt;
  logic            r_armed, w_armed_nxt;
  logic            r_loadn;
  logic            r_busy;
  logic [9:0]      w_key_edge;
  logic            w_start_ev, w_clear_ev, w_press;
  bcd_key_t        w_key;

  edge_det #(.WIDTH(10), .FALLING(1'b0), .FROM_QUIET(1'b1)) u_key_edge (
    .i_clk  (clk),
    .i_rst_n(clrn),
    .i_sig  (key),
    .o_edge (w_key_edge)
  );

  edge_det #(.WIDTH(1), .FALLING(1'b1), .FROM_QUIET(1'b0)) u_start_edge (
    .i_clk  (clk),
    .i_rst_n(clrn),
    .i_sig  (startn),
    .o_edge (w_start_ev)
  );

  edge_det #(.WIDTH(1), .FALLING(1'b1), .FROM_QUIET(1'b0)) u_clear_edge (
    .i_clk  (clk),
    .i_rst_n(clrn),
    .i_sig  (cleann),
    .o_edge (w_clear_ev)
  );

  assign w_key        = onehot_to_bcd(key);
  assign w_press      = w_key.valid && (w_key_edge != '0);
  assign w_data_shift = {r_data[DW-BCD_W-1:0], w_key.bcd};

  // seconds tens beyond the limit snap to the largest legal seconds value
  always_comb begin
    w_data_clamped = r_data;
    if (CLAMP_EN && (r_data[7:4] > BCD_W'(SEC_LIMIT)))
      w_data_clamped[7:0] = {BCD_W'(SEC_LIMIT), BCD_W'(BCD_MAX)};
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_ndigits_nxt = r_ndigits;
    w_armed_nxt   = r_armed;
    case (r_state)
      IDLE: begin
        if (w_press && (w_key.bcd != '0)) begin
          w_data_nxt    = w_data_shift;
          w_ndigits_nxt = NW'(1);
          w_state_nxt   = ENTRY;
        end
      end
      ENTRY: begin
        if (w_start_ev) begin
          w_data_nxt  = w_data_clamped;
          w_state_nxt = LOAD;
        end else if (w_press && (r_ndigits < NW'(DIGITS))) begin
          w_data_nxt    = w_data_shift;
          w_ndigits_nxt = r_ndigits + NW'(1);
        end
      end
      LOAD: begin
        w_armed_nxt = 1'b0;
        w_state_nxt = HOLD;
      end
      HOLD: begin
        if (r_armed && timer_zero) begin
          w_data_nxt    = '0;
          w_ndigits_nxt = '0;
          w_armed_nxt   = 1'b0;
          w_state_nxt   = IDLE;
        end else if (!timer_zero) begin
          w_armed_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_clear_ev) begin
      w_data_nxt    = '0;
      w_ndigits_nxt = '0;
      w_armed_nxt   = 1'b0;
      w_state_nxt   = IDLE;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state   <= IDLE;
      r_data    <= '0;
      r_ndigits <= '0;
      r_armed   <= 1'b0;
      r_loadn   <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_ndigits <= w_ndigits_nxt;
      r_armed   <= w_armed_nxt;
      // strobe follows LOAD unconditionally so a clear in LOAD still loads
      r_loadn   <= (r_state != LOAD);
      r_busy    <= (w_state_nxt == LOAD) || (w_state_nxt == HOLD);
    end
  end

  assign data    = r_data;
  assign ndigits = r_ndigits;
  assign loadn   = r_loadn;
  assign busy    = r_busy;

endmodule
